// File: rtl/gen_inm_if.sv
// Instruction/immediate bundle between the decode stage and the immediate generator.
// The master drives the instruction side and the slave returns the registered immediate.
interface gen_inm_if;
   logic [31:0] instr;
   logic [2:0]  IMMSrc;
   logic        in_valid;
   logic [31:0] imm_out;
   logic        out_valid;
   logic        imm_err;

   modport master (
      output instr,
      output IMMSrc,
      output in_valid,
      input  imm_out,
      input  out_valid,
      input  imm_err
   );

   modport slave (
      input  instr,
      input  IMMSrc,
      input  in_valid,
      output imm_out,
      output out_valid,
      output imm_err
   );
endinterface

// File: rtl/gen_inm.sv
// RV32I immediate generator: extracts and extends the immediate selected by IMMSrc
// and presents it one cycle later from flops, flagging the reserved select code.
module gen_inm (
   input  logic       clk,
   input  logic       rst,
   gen_inm_if.slave   bus
);

   typedef enum logic [2:0] {
      SEL_I     = 3'b000,
      SEL_S     = 3'b001,
      SEL_U     = 3'b010,
      SEL_J     = 3'b011,
      SEL_SHAMT = 3'b100,
      SEL_B     = 3'b101,
      SEL_ZIMM  = 3'b110,
      SEL_RSVD  = 3'b111
   } imm_sel_t;

   imm_sel_t    sel;
   logic [31:0] imm_next;
   logic        err_next;
   logic        sign;

   assign sel  = imm_sel_t'(bus.IMMSrc);
   assign sign = bus.instr[31];

   always_comb begin
      imm_next = 32'h0;
      err_next = 1'b0;
      case (sel)
         SEL_I:     imm_next = {{20{sign}}, bus.instr[31:20]};
         SEL_S:     imm_next = {{20{sign}}, bus.instr[31:25], bus.instr[11:7]};
         SEL_U:     imm_next = {bus.instr[31:12], 12'b0};
         SEL_J:     imm_next = {{11{sign}}, bus.instr[31], bus.instr[19:12],
                                bus.instr[20], bus.instr[30:21], 1'b0};
         SEL_SHAMT: imm_next = {27'b0, bus.instr[24:20]};
         SEL_B:     imm_next = {{19{sign}}, bus.instr[31], bus.instr[7],
                                bus.instr[30:25], bus.instr[11:8], 1'b0};
         SEL_ZIMM:  imm_next = {27'b0, bus.instr[19:15]};
         SEL_RSVD:  err_next = 1'b1;
         default:   err_next = 1'b1;
      endcase
   end

   // Idle cycles keep the last immediate visible but withdraw out_valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.imm_out   <= 32'h0;
         bus.imm_err   <= 1'b0;
         bus.out_valid <= 1'b0;
      end else if (bus.in_valid) begin
         bus.imm_out   <= imm_next;
         bus.imm_err   <= err_next;
         bus.out_valid <= 1'b1;
      end else begin
         bus.out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_gen_inm.sv
// Self-checking bench for gen_inm: directed immediate vectors, valid/reset handling,
// and randomized traffic compared against an arithmetic reference model.
module tb_gen_inm;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   gen_inm_if bus ();

   gen_inm dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Immediate value computed as a signed integer from the ISA field layout.
   function automatic logic [31:0] model_imm(input logic [31:0] w, input logic [2:0] s);
      int v;
      v = 0;
      case (s)
         3'd0: begin
            v = int'(w[31:20]);
            if (w[31]) v = v - 4096;
         end
         3'd1: begin
            v = int'(w[31:25]) * 32 + int'(w[11:7]);
            if (w[31]) v = v - 4096;
         end
         3'd2: v = int'(w[31:12]) * 4096;
         3'd3: begin
            v = int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
            if (w[31]) v = v - 1048576;
         end
         3'd4: v = int'(w[24:20]);
         3'd5: begin
            v = int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
            if (w[31]) v = v - 4096;
         end
         3'd6: v = int'(w[19:15]);
         default: v = 0;
      endcase
      return 32'(v);
   endfunction

   task automatic drive_cycle(input logic [31:0] i, input logic [2:0] s,
                              input logic v, input logic r);
      bus.instr    = i;
      bus.IMMSrc   = s;
      bus.in_valid = v;
      rst          = r;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      drive_cycle(32'hFFFF_FFFF, 3'd0, 1'b1, 1'b1);
      checks += 3;
      if (bus.imm_out !== 32'h0) begin
         errors++; $display("[TB] FAIL reset_imm: got %h expected %h", bus.imm_out, 32'h0);
      end
      if (bus.out_valid !== 1'b0) begin
         errors++; $display("[TB] FAIL reset_valid: got %b expected 0", bus.out_valid);
      end
      if (bus.imm_err !== 1'b0) begin
         errors++; $display("[TB] FAIL reset_err: got %b expected 0", bus.imm_err);
      end
   endtask

   task automatic test_directed();
      logic [31:0] vin  [14];
      logic [2:0]  vsel [14];
      logic [31:0] vexp [14];
      vin[0]  = 32'h7FF0_0000; vsel[0]  = 3'd0; vexp[0]  = 32'h0000_07FF;
      vin[1]  = 32'hFFF0_0000; vsel[1]  = 3'd0; vexp[1]  = 32'hFFFF_FFFF;
      vin[2]  = 32'h1200_0180; vsel[2]  = 3'd1; vexp[2]  = 32'h0000_0123;
      vin[3]  = 32'hFE00_0F80; vsel[3]  = 3'd1; vexp[3]  = 32'hFFFF_FFFF;
      vin[4]  = 32'h0000_0400; vsel[4]  = 3'd5; vexp[4]  = 32'h0000_0008;
      vin[5]  = 32'h0000_0800; vsel[5]  = 3'd5; vexp[5]  = 32'h0000_0010;
      vin[6]  = 32'h8000_0000; vsel[6]  = 3'd5; vexp[6]  = 32'hFFFF_F000;
      vin[7]  = 32'hFFFF_FFFF; vsel[7]  = 3'd2; vexp[7]  = 32'hFFFF_F000;
      vin[8]  = 32'hFFFF_FFFF; vsel[8]  = 3'd3; vexp[8]  = 32'hFFFF_FFFE;
      vin[9]  = 32'hFFFF_FFFF; vsel[9]  = 3'd4; vexp[9]  = 32'h0000_001F;
      vin[10] = 32'hFFFF_FFFF; vsel[10] = 3'd6; vexp[10] = 32'h0000_001F;
      vin[11] = 32'hFFFF_FFFF; vsel[11] = 3'd7; vexp[11] = 32'h0000_0000;
      vin[12] = 32'hFFFF_FFFF; vsel[12] = 3'd5; vexp[12] = 32'hFFFF_FFFE;
      vin[13] = 32'h0000_007F; vsel[13] = 3'd0; vexp[13] = 32'h0000_0000;
      for (int k = 0; k < 14; k++) begin
         drive_cycle(vin[k], vsel[k], 1'b1, 1'b0);
         checks += 3;
         if (bus.imm_out !== vexp[k]) begin
            errors++;
            $display("[TB] FAIL directed_imm[%0d]: got %h expected %h", k, bus.imm_out, vexp[k]);
         end
         if (bus.imm_err !== (vsel[k] == 3'd7)) begin
            errors++;
            $display("[TB] FAIL directed_err[%0d]: got %b expected %b", k, bus.imm_err, vsel[k] == 3'd7);
         end
         if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL directed_valid[%0d]: got %b expected 1", k, bus.out_valid);
         end
      end
   endtask

   task automatic test_valid_drop();
      drive_cycle(32'h7FF0_0000, 3'd0, 1'b1, 1'b0);
      drive_cycle(32'h0000_0000, 3'd7, 1'b0, 1'b0);
      checks += 3;
      if (bus.out_valid !== 1'b0) begin
         errors++; $display("[TB] FAIL drop_valid: got %b expected 0", bus.out_valid);
      end
      if (bus.imm_out !== 32'h0000_07FF) begin
         errors++; $display("[TB] FAIL drop_hold_imm: got %h expected %h", bus.imm_out, 32'h0000_07FF);
      end
      if (bus.imm_err !== 1'b0) begin
         errors++; $display("[TB] FAIL drop_hold_err: got %b expected 0", bus.imm_err);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] w;
      logic [2:0]  s;
      logic [31:0] exp_imm;
      drive_cycle(32'hFFFF_FFFF, 3'd3, 1'b1, 1'b0);
      drive_cycle(32'h1234_5678, 3'd0, 1'b1, 1'b1);
      checks += 3;
      if (bus.imm_out !== 32'h0) begin
         errors++; $display("[TB] FAIL midreset_imm: got %h expected %h", bus.imm_out, 32'h0);
      end
      if (bus.out_valid !== 1'b0) begin
         errors++; $display("[TB] FAIL midreset_valid: got %b expected 0", bus.out_valid);
      end
      if (bus.imm_err !== 1'b0) begin
         errors++; $display("[TB] FAIL midreset_err: got %b expected 0", bus.imm_err);
      end
      for (int k = 0; k < 6; k++) begin
         w = $urandom;
         s = 3'(k);
         exp_imm = model_imm(w, s);
         drive_cycle(w, s, 1'b1, 1'b0);
         checks += 2;
         if (bus.imm_out !== exp_imm) begin
            errors++;
            $display("[TB] FAIL b2b_imm[%0d]: got %h expected %h", k, bus.imm_out, exp_imm);
         end
         if (bus.out_valid !== 1'b1) begin
            errors++; $display("[TB] FAIL b2b_valid[%0d]: got %b expected 1", k, bus.out_valid);
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] w;
      logic [2:0]  s;
      logic        v;
      logic        r;
      logic [31:0] exp_imm;
      logic        exp_err;
      logic        exp_vld;
      exp_imm = bus.imm_out;
      exp_err = bus.imm_err;
      exp_vld = bus.out_valid;
      for (int k = 0; k < 400; k++) begin
         w = $urandom;
         s = 3'($urandom_range(0, 7));
         v = ($urandom_range(0, 3) != 0);
         r = ($urandom_range(0, 24) == 0);
         drive_cycle(w, s, v, r);
         if (r) begin
            exp_imm = 32'h0; exp_err = 1'b0; exp_vld = 1'b0;
         end else if (v) begin
            exp_imm = model_imm(w, s); exp_err = (s == 3'd7); exp_vld = 1'b1;
         end else begin
            exp_vld = 1'b0;
         end
         checks += 3;
         if (bus.imm_out !== exp_imm) begin
            errors++;
            $display("[TB] FAIL rand_imm[%0d] sel=%0d instr=%h: got %h expected %h",
                     k, s, w, bus.imm_out, exp_imm);
         end
         if (bus.imm_err !== exp_err) begin
            errors++; $display("[TB] FAIL rand_err[%0d]: got %b expected %b", k, bus.imm_err, exp_err);
         end
         if (bus.out_valid !== exp_vld) begin
            errors++; $display("[TB] FAIL rand_valid[%0d]: got %b expected %b", k, bus.out_valid, exp_vld);
         end
      end
   endtask

   initial begin
      checks       = 0;
      errors       = 0;
      rst          = 1'b1;
      bus.instr    = 32'h0;
      bus.IMMSrc   = 3'd0;
      bus.in_valid = 1'b0;
      test_reset();
      test_directed();
      test_valid_drop();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
